// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I core.
// Sequences memory, ALU, PC, IR and register file over several cycles.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       trap
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  state_t state;
  state_t state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:
        if (mem_ready) state_n = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_n = S_MEMADR;
          (op == OP_R):   state_n = S_EXECR;
          (op == OP_I):   state_n = S_EXECI;
          (op == OP_BEQ): state_n = S_BEQ;
          (op == OP_JAL): state_n = S_JAL;
          default:        state_n = S_TRAP;
        endcase
      S_MEMADR:
        state_n = (op == OP_SW) ? S_MEMWRITE
                                : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BEQ:      state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
      S_TRAP:     state_n = S_TRAP;
      default:    state_n = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so the datapath sees all zeros in reset.
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (op == OP_SW):  imm_src = 2'b01;
        (op == OP_BEQ): imm_src = 2'b10;
        (op == OP_JAL): imm_src = 2'b11;
        default:        imm_src = 2'b00;
      endcase
      unique case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for the multicycle control FSM.
// Expected control words come from an instruction-level plan model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       instr_done;
    logic       trap;
  } ctl_t;

  typedef struct packed {
    ctl_t e;
    logic rdy;
    logic z;
  } step_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_write, pc_write;
  logic       mem_write, reg_write, instr_done, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0] alu_op, imm_src;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write),
    .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .instr_done(instr_done),
    .trap(trap)
  );

  always #5 clk = ~clk;

  ctl_t  sb[$];
  step_t plan[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_cyc = 0;
  int    n_ret = 0;
  int    exp_ret = 0;
  logic [6:0] cur_op;

  // Monitor: one expected control word per cycle.
  always @(negedge clk) begin
    ctl_t e, a;
    n_cyc++;
    a = {mem_req, adr_src, ir_write, pc_write,
         mem_write, reg_write, result_src,
         alu_src_a, alu_src_b, alu_op, imm_src,
         instr_done, trap};
    if (a.instr_done === 1'b1) n_ret++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d op=%b got %b exp %b",
                 n_cyc, op, a, e);
      end
    end
  end

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(ctl_t e, logic r, logic z);
    step_t s;
    s.e = e; s.rdy = r; s.z = z;
    plan.push_back(s);
  endtask

  task automatic add_aluwb(ctl_t base);
    ctl_t e;
    e = base;
    e.reg_write = 1'b1;
    e.instr_done = 1'b1;
    add(e, rb(), rb());
  endtask

  // Build the cycle-by-cycle plan of one instruction.
  task automatic build(logic [6:0] o, int wf, int wm,
                       logic z, int ntrap);
    ctl_t base, e;
    base = '0;
    base.imm_src = imm_of(o);
    plan.delete();
    e = base;
    e.mem_req = 1'b1;
    e.alu_src_b = 2'b10;
    e.result_src = 2'b10;
    for (int i = 0; i < wf; i++) add(e, 1'b0, rb());
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    add(e, 1'b1, rb());
    e = base;
    e.alu_src_a = 2'b01;
    e.alu_src_b = 2'b01;
    add(e, rb(), rb());
    if (o == LW || o == SW) begin
      e = base;
      e.alu_src_a = 2'b10;
      e.alu_src_b = 2'b01;
      add(e, rb(), rb());
      e = base;
      e.mem_req = 1'b1;
      e.adr_src = 1'b1;
      e.mem_write = (o == SW);
      for (int i = 0; i < wm; i++) add(e, 1'b0, rb());
      e.instr_done = (o == SW);
      add(e, 1'b1, rb());
      if (o == LW) begin
        e = base;
        e.result_src = 2'b01;
        e.reg_write = 1'b1;
        e.instr_done = 1'b1;
        add(e, rb(), rb());
      end
    end else if (o == RT || o == IT) begin
      e = base;
      e.alu_src_a = 2'b10;
      e.alu_src_b = (o == IT) ? 2'b01 : 2'b00;
      e.alu_op = 2'b10;
      add(e, rb(), rb());
      add_aluwb(base);
    end else if (o == BEQ) begin
      e = base;
      e.alu_src_a = 2'b10;
      e.alu_op = 2'b01;
      e.pc_write = z;
      e.instr_done = 1'b1;
      add(e, rb(), z);
    end else if (o == JAL) begin
      e = base;
      e.alu_src_a = 2'b01;
      e.alu_src_b = 2'b10;
      e.pc_write = 1'b1;
      add(e, rb(), rb());
      add_aluwb(base);
    end else begin
      e = base;
      e.trap = 1'b1;
      for (int i = 0; i < ntrap; i++) add(e, rb(), rb());
    end
  endtask

  task automatic step(ctl_t e, logic r, logic z);
    sb.push_back(e);
    mem_ready = r;
    zero = z;
    @(posedge clk);
    #1;
  endtask

  task automatic run(logic [6:0] o, int upto);
    int n;
    op = o;
    n = (upto < plan.size()) ? upto : plan.size();
    for (int i = 0; i < n; i++)
      step(plan[i].e, plan[i].rdy, plan[i].z);
  endtask

  task automatic instr(logic [6:0] o, int wf, int wm, logic z);
    build(o, wf, wm, z, 0);
    run(o, plan.size());
    exp_ret++;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      op = 7'($urandom);
      step('0, rb(), rb());
    end
    rst_n = 1'b1;
  endtask

  logic [6:0] legal [6];

  initial begin
    legal[0] = LW;  legal[1] = SW;
    legal[2] = RT;  legal[3] = IT;
    legal[4] = BEQ; legal[5] = JAL;
    rst_n = 1'b0;
    op = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);
    instr(RT, 0, 0, 1'b0);
    instr(LW, 2, 2, 1'b0);
    instr(SW, 0, 1, 1'b0);
    instr(BEQ, 0, 0, 1'b1);
    instr(BEQ, 0, 0, 1'b0);
    instr(JAL, 0, 0, 1'b0);
    build(7'b0000000, 0, 0, 1'b0, 12);
    run(7'b0000000, plan.size());
    do_reset(2);
    for (int k = 0; k < 150; k++) begin
      logic [6:0] o;
      o = legal[$urandom_range(0, 5)];
      build(o, $urandom_range(0, 3), $urandom_range(0, 3),
            rb(), 0);
      if ($urandom_range(0, 7) == 0) begin
        run(o, $urandom_range(1, plan.size() - 1));
        do_reset($urandom_range(1, 2));
      end else begin
        run(o, plan.size());
        exp_ret++;
      end
    end
    build(7'b1110011, 1, 0, 1'b0, 10);
    run(7'b1110011, plan.size());
    do_reset(1);
    instr(IT, 1, 0, 1'b0);
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d expected 0", sb.size());
    end
    n_chk++;
    if (n_ret != exp_ret) begin
      n_fail++;
      $display("FAIL retire got %0d expected %0d",
               n_ret, exp_ret);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
